pmem_line_responder: RTL

- Physical-memory side responder for the cache's line-fill/writeback interface.
- Accepts one 128-bit line read or write at a time from the cache controller's pmem_* master, which uses a level-held request and a single-cycle response.
- Backs requests with an internal line array and a programmable fixed access latency.
- Used as a synthesizable backing store for cache bring-up and as the reference responder in cache testbenches.

---
 rtl/pmem_line_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//   Physical-memory side responder for a cache line-fill/writeback port.
//   Serves one 128-bit line read or write at a time from an internal line
//   array, answering a fixed LATENCY cycles after the request is accepted.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   pmem_read     line read request, level-held until pmem_resp
//   pmem_write    line write request, level-held until pmem_resp
//   pmem_address  byte address; line index = pmem_address[4+INDEX_BITS-1:4]
//   pmem_wdata    write line data
//   pmem_resp     one-cycle completion pulse
//   pmem_rdata    read line data, valid in the pmem_resp cycle of a read
//   busy          high while a request is in flight
//   proto_err     sticky flag, read and write requested together
module pmem_line_responder #(
   parameter int INDEX_BITS = 5,
   parameter int LATENCY    = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic         pmem_resp,
   output logic [127:0] pmem_rdata,
   output logic         busy,
   output logic         proto_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] CNT_LOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

   state_t                  state, next_state;
   logic [7:0]              cnt;
   logic                    op_write;
   logic [INDEX_BITS-1:0]   idx_q;
   logic [127:0]            wdata_q;
   logic [127:0]            mem [2**INDEX_BITS];

   logic                    accept;
   logic [INDEX_BITS-1:0]   addr_idx;
   logic [INDEX_BITS-1:0]   rd_idx;
   logic                    rd_is_write;
   logic                    unused_addr;

   assign addr_idx    = pmem_address[4+INDEX_BITS-1:4];
   assign unused_addr = ^{pmem_address[15:4+INDEX_BITS], pmem_address[3:0]};
   assign accept      = (state == IDLE) && (pmem_read || pmem_write);

   // With LATENCY==1 the response is loaded on the acceptance edge itself,
   // before the captured registers exist, so look at the live inputs then.
   assign rd_idx      = (state == IDLE) ? addr_idx   : idx_q;
   assign rd_is_write = (state == IDLE) ? pmem_write : op_write;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt == 8'd0) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // output logic
   always_comb begin
      busy = (state != IDLE);
   end

   // capture, counter and registered response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt        <= 8'd0;
         op_write   <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         pmem_resp  <= 1'b0;
         pmem_rdata <= '0;
         proto_err  <= 1'b0;
      end else begin
         pmem_resp <= (next_state == RESP);
         if (accept) begin
            op_write <= pmem_write;   // read+write together is served as a write
            idx_q    <= addr_idx;
            wdata_q  <= pmem_wdata;
            cnt      <= CNT_LOAD;
            if (pmem_read && pmem_write) proto_err <= 1'b1;
         end else if (state == WAIT && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (next_state == RESP && state != RESP && !rd_is_write)
            pmem_rdata <= mem[rd_idx];
      end
   end

   // Write commits on the edge leaving RESP, so a following read (accepted
   // no earlier than the next edge) always sees it. Reset forces IDLE, which
   // discards an in-flight write.
   always_ff @(posedge clk) begin
      if (state == RESP && op_write)
         mem[idx_q] <= wdata_q;
   end

endmodule
